pipe_register_file: RTL and testbench
=====================================

PIPE_REGISTER_FILE -- requirements
Module: pipe_register_file

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 Port clk  in  1: rising-edge clock; one clock domain only.
REQ-005 Port clr_n  in  1: asynchronous, active-low reset.
REQ-006 Port a_addr  in  ADDR_W: read port A address.
REQ-007 Port b_addr  in  ADDR_W: read port B address.
REQ-008 Port a_data  out  DATA_W: read port A data.
REQ-009 Port b_data  out  DATA_W: read port B data.
REQ-010 Port a_busy  out  1: register at a_addr has a pending producer.
REQ-011 Port b_busy  out  1: register at b_addr has a pending producer.
REQ-012 Port wr_en  in  1: write strobe.
REQ-013 Port wr_addr  in  ADDR_W: write address.
REQ-014 Port wr_data  in  DATA_W: write data.
REQ-015 Port rsv_en  in  1: reserve strobe; marks a destination register pending at instruction issue.
REQ-016 Port rsv_addr  in  ADDR_W: reserve address.
REQ-017 Port pend_cnt  out  ADDR_W+1: number of registers currently pending.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W flops, written on the rising clk edge when wr_en=1.
REQ-019 Reads SHALL be combinational; a_data = reg[a_addr] and b_data = reg[b_addr].
REQ-020 Bypass: when wr_en=1 and wr_addr equals a read address, that read port SHALL return wr_data in the same cycle.
REQ-021 With ZERO_REG=1, address 0 SHALL read 0 and SHALL never be busy, bypass, store, or reserve.
REQ-022 Scoreboard: there SHALL be one pending bit per register; rsv_en=1 sets pend[rsv_addr] at the clk edge.
REQ-023 wr_en=1 SHALL clear pend[wr_addr] at the clk edge.
REQ-024 Simultaneous rsv_en and wr_en to the same address: the data is written and the pending bit SHALL end set, because the new producer wins.
REQ-025 rsv_en to an already-pending register: the bit SHALL stay set and pend_cnt SHALL not change.
REQ-026 wr_en to a non-pending register: the data is written, the bit SHALL stay clear, and pend_cnt SHALL not change.
REQ-027 a_busy = pend[a_addr] and b_busy = pend[b_addr], except that a same-cycle write to that address SHALL force busy=0, consistent with bypass.
REQ-028 pend_cnt SHALL be a registered count updated each edge by +1, -1, or 0 according to the net change in pending bits.
REQ-029 pend_cnt SHALL never wrap; its range is 0..DEPTH (0..DEPTH-1 with ZERO_REG=1).

Reset
REQ-030 clr_n=0 SHALL immediately, without waiting for clk, clear all registers to 0, all pending bits to 0, and pend_cnt to 0.
REQ-031 While clr_n=0, a_data and b_data SHALL read 0 unless bypassed, and a_busy and b_busy SHALL be 0.
REQ-032 While clr_n=0, wr_en and rsv_en SHALL have no effect.
REQ-033 On release of clr_n, normal operation SHALL start at the first rising clk edge.
REQ-034 Reset asserted mid-operation SHALL discard all pending reservations.

Verification
REQ-035 Reset then read all addresses -> every a_data and b_data is 0, busy is 0, pend_cnt is 0.
REQ-036 Write 0x0005 to r6; next cycle a_addr=6 -> a_data=0x0005; write r0=0xFFFF, then a_addr=0 -> a_data=0x0000.
REQ-037 wr_en=1, wr_addr=2, wr_data=0x1234 with b_addr=2 in the same cycle -> b_data=0x1234 before the edge.
REQ-038 Reserve r3, next cycle a_addr=3 -> a_busy=1 and pend_cnt=1; write r3=0x00AA -> same-cycle a_busy=0, after the edge pend_cnt=0 and a_data=0x00AA.
REQ-039 rsv_en and wr_en both to r5 in one cycle -> r5 holds the new data, pend[5]=1, pend_cnt=1.
REQ-040 Reserve r1, r2, r4, then assert clr_n=0 between clk edges -> pend_cnt=0 and all busy=0 immediately; parameter sweep DATA_W=32, ADDR_W=5 repeats REQ-036.

Source files
------------

// File: rtl/pipe_register_file.sv
// Register file with a per-register pending scoreboard for in-order issue.
// Read ports are combinational and bypass a same-cycle write; pend_cnt tracks how many registers await a producer.
module pipe_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic              a_busy,
    output logic              b_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_q;
    logic              wr_ok;
    logic              rsv_ok;
    logic              set_new;
    logic              clr_old;

    // Register 0 is hard-wired to zero when ZERO_REG is set: it neither stores nor reserves.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_comb begin
        a_data = regs[a_addr];
        b_data = regs[b_addr];
        if ((ZERO_REG != 0) && (a_addr == '0)) a_data = '0;
        if ((ZERO_REG != 0) && (b_addr == '0)) b_data = '0;
        if (wr_ok && (wr_addr == a_addr)) a_data = wr_data;
        if (wr_ok && (wr_addr == b_addr)) b_data = wr_data;
    end

    // A write arriving this cycle satisfies the consumer, so busy drops together with the bypass.
    assign a_busy = pend[a_addr] && !(wr_ok && (wr_addr == a_addr));
    assign b_busy = pend[b_addr] && !(wr_ok && (wr_addr == b_addr));

    always_comb begin
        pend_nxt = pend;
        if (wr_ok)  pend_nxt[wr_addr]  = 1'b0;
        if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
    end

    // Net change in pending bits; a reserve and write to the same register leaves it pending.
    assign set_new = rsv_ok && !pend[rsv_addr];
    assign clr_old = wr_ok && pend[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend  <= '0;
            cnt_q <= '0;
        end else begin
            pend <= pend_nxt;
            case ({set_new, clr_old})
                2'b10:   cnt_q <= cnt_q + (ADDR_W + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (ADDR_W + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_register_file.sv
// Bench for pipe_register_file: array-based reference model feeding an expected queue,
// a negedge monitor that pops and compares, plus a directed run on a 32x32 instance.
module tb_pipe_register_file;

    localparam int EW = 39;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  a_addr, b_addr, wr_addr, rsv_addr;
    logic [15:0] a_data, b_data, wr_data;
    logic        a_busy, b_busy, wr_en, rsv_en;
    logic [4:0]  pend_cnt;

    logic        p_clr_n;
    logic [4:0]  p_a_addr, p_b_addr, p_wr_addr, p_rsv_addr;
    logic [31:0] p_a_data, p_b_data, p_wr_data;
    logic        p_a_busy, p_b_busy, p_wr_en, p_rsv_en;
    logic [5:0]  p_pend_cnt;

    logic [EW-1:0] exp_q[$];
    logic          chk_valid = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic [15:0] m_reg [16];
    logic        m_pend [16];

    always #5 clk = ~clk;

    pipe_register_file dut (
        .clk(clk), .clr_n(clr_n),
        .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
        .a_busy(a_busy), .b_busy(b_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt)
    );

    pipe_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_wide (
        .clk(clk), .clr_n(p_clr_n),
        .a_addr(p_a_addr), .b_addr(p_b_addr), .a_data(p_a_data), .b_data(p_b_data),
        .a_busy(p_a_busy), .b_busy(p_b_busy),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr), .pend_cnt(p_pend_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus at posedge+1, records the expected outputs, then advances the model at the edge.
    task automatic cycle(input logic cl, input logic [3:0] aa, input logic [3:0] ba,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic re, input logic [3:0] ra);
        logic [15:0] ea, eb;
        logic        eab, ebb;
        int          n;
        clr_n = cl; a_addr = aa; b_addr = ba;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        if (!cl) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i] = '0;
                m_pend[i] = 1'b0;
            end
        end
        ea  = (we && wa == aa && aa != 0) ? wd : ((aa == 0) ? 16'h0 : m_reg[aa]);
        eb  = (we && wa == ba && ba != 0) ? wd : ((ba == 0) ? 16'h0 : m_reg[ba]);
        eab = m_pend[aa] && !(we && wa == aa);
        ebb = m_pend[ba] && !(we && wa == ba);
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
        exp_q.push_back({ea, eb, eab, ebb, 5'(n)});
        chk_valid = 1'b1;
        @(posedge clk);
        if (cl) begin
            if (we && wa != 0) begin
                m_reg[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (re && ra != 0) m_pend[ra] = 1'b1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue: got empty expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("a_data", 32'(a_data), 32'(e[38:23]));
                chk("b_data", 32'(b_data), 32'(e[22:7]));
                chk("a_busy", 32'(a_busy), 32'(e[6]));
                chk("b_busy", 32'(b_busy), 32'(e[5]));
                chk("pend_cnt", 32'(pend_cnt), 32'(e[4:0]));
            end
        end
    end

    initial begin
        logic [3:0]  ra, wa;
        clr_n = 1'b0; a_addr = '0; b_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
        p_clr_n = 1'b0; p_a_addr = '0; p_b_addr = '0; p_wr_en = 1'b0; p_wr_addr = '0;
        p_wr_data = '0; p_rsv_en = 1'b0; p_rsv_addr = '0;
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then every address after release
        cycle(1'b0, 4'd3, 4'd9, 1'b1, 4'd3, 16'h7777, 1'b1, 4'd3);
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 4'(15 - i), 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

        // Write then read, and register 0 stays zero
        cycle(1'b1, 4'd0, 4'd0, 1'b1, 4'd6, 16'h0005, 1'b0, 4'd0);
        cycle(1'b1, 4'd6, 4'd0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
        cycle(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
        cycle(1'b1, 4'd0, 4'd6, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);

        // Same-cycle bypass
        cycle(1'b1, 4'd0, 4'd2, 1'b1, 4'd2, 16'h1234, 1'b0, 4'd0);
        cycle(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);

        // Reserve, observe busy, retire with a write
        cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd3);
        cycle(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 16'h0,    1'b1, 4'd3);
        cycle(1'b1, 4'd3, 4'd0, 1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0);
        cycle(1'b1, 4'd3, 4'd3, 1'b1, 4'd9, 16'h0099, 1'b0, 4'd0);

        // Reserve and write the same register in one cycle
        cycle(1'b1, 4'd0, 4'd0, 1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5);
        cycle(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0);
        cycle(1'b1, 4'd5, 4'd0, 1'b1, 4'd5, 16'h0101, 1'b0, 4'd0);

        // Reserve several, then reset between edges
        cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd1);
        cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2);
        cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
        cycle(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        cycle(1'b0, 4'd1, 4'd4, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        cycle(1'b0, 4'd2, 4'd6, 1'b1, 4'd2, 16'h4242, 1'b1, 4'd2);
        cycle(1'b1, 4'd2, 4'd4, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

        // Randomized traffic with occasional same-address collisions and resets
        for (int k = 0; k < 1500; k++) begin
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 4), wa, 16'($urandom()),
                  ($urandom_range(0, 9) < 4), ra);
        end
        chk_valid = 1'b0;
        clr_n = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;

        // Wide instance: 32-bit data, 32 registers
        @(posedge clk); #1;
        p_clr_n = 1'b1;
        p_wr_en = 1'b1; p_wr_addr = 5'd6; p_wr_data = 32'h0000_0005;
        @(posedge clk); #1;
        p_wr_en = 1'b0; p_a_addr = 5'd6;
        @(negedge clk);
        chk("wide_a_data_r6", p_a_data, 32'h0000_0005);
        @(posedge clk); #1;
        p_wr_en = 1'b1; p_wr_addr = 5'd0; p_wr_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        p_wr_addr = 5'd31; p_wr_data = 32'hDEAD_BEEF; p_a_addr = 5'd0;
        @(posedge clk); #1;
        p_wr_en = 1'b0; p_b_addr = 5'd31;
        @(negedge clk);
        chk("wide_a_data_r0", p_a_data, 32'h0);
        chk("wide_b_data_r31", p_b_data, 32'hDEAD_BEEF);
        chk("wide_pend_cnt", 32'(p_pend_cnt), 32'h0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
